// File: rtl/sd_demodulator.sv
// sd_demodulator: 1-bit sigma-delta bitstream to PCM using a 3rd-order CIC decimator.
// The integrators wrap freely; the comb differences recover the exact in-range result.
module sd_demodulator #(
    parameter int pBITS     = 24,
    parameter int pDEC_BITS = 5
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iBIT,
    output logic [pBITS-1:0] oDATA,
    output logic             oSTROBE
);
    localparam int W = 3*pDEC_BITS+2;
    localparam int N = 3*pDEC_BITS+1;
    localparam logic [W-1:0]     FULL = W'(1) << (3*pDEC_BITS);
    localparam logic [N-1:0]     MAXP = {1'b0, {(N-1){1'b1}}};
    localparam logic [pBITS-1:0] MID  = pBITS'(1) << (pBITS-1);

    if (pBITS < N) begin : g_width_check
        $error("pBITS must be >= 3*pDEC_BITS+1");
    end

    logic                 rbit_q, rbit_d;
    logic [W-1:0]         i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic [W-1:0]         d3_q, d3_d, c1_q, c1_d, d1_q, d1_d;
    logic [W-1:0]         c2_q, c2_d, d2_q, d2_d, c3_q, c3_d;
    logic [pDEC_BITS-1:0] cnt_q, cnt_d;
    logic [1:0]           warm_q, warm_d, t_q, t_d;
    logic [2:0]           v_q, v_d;
    logic [pBITS-1:0]     data_q, data_d;
    logic                 stb_q, stb_d;
    logic                 tick;
    logic [N-1:0]         trunc;

    // t_q steps the comb stages on every tick; v_q carries only post-warm-up ticks to the output.
    always_comb begin
        tick   = &cnt_q;
        rbit_d = iBIT;
        i1_d   = i1_q + (rbit_q ? W'(1) : {W{1'b1}});
        i2_d   = i2_q + i1_q;
        i3_d   = i3_q + i2_q;
        cnt_d  = cnt_q + pDEC_BITS'(1);
        warm_d = (tick && warm_q != 2'd3) ? warm_q + 2'd1 : warm_q;
        d3_d   = tick ? i3_q : d3_q;
        c1_d   = tick ? i3_q - d3_q : c1_q;
        d1_d   = t_q[0] ? c1_q : d1_q;
        c2_d   = t_q[0] ? c1_q - d1_q : c2_q;
        d2_d   = t_q[1] ? c2_q : d2_q;
        c3_d   = t_q[1] ? c2_q - d2_q : c3_q;
        t_d    = {t_q[0], tick};
        v_d    = {v_q[1:0], tick && warm_q == 2'd3};
        trunc  = (c3_q == FULL) ? MAXP : c3_q[N-1:0];
        stb_d  = v_q[2];
        data_d = v_q[2] ? pBITS'({~trunc[N-1], trunc[N-2:0]}) << (pBITS-N) : data_q;
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            rbit_q <= 1'b0;
            i1_q   <= '0;
            i2_q   <= '0;
            i3_q   <= '0;
            d3_q   <= '0;
            c1_q   <= '0;
            d1_q   <= '0;
            c2_q   <= '0;
            d2_q   <= '0;
            c3_q   <= '0;
            cnt_q  <= '0;
            warm_q <= '0;
            t_q    <= '0;
            v_q    <= '0;
            data_q <= MID;
            stb_q  <= 1'b0;
        end else begin
            rbit_q <= rbit_d;
            i1_q   <= i1_d;
            i2_q   <= i2_d;
            i3_q   <= i3_d;
            d3_q   <= d3_d;
            c1_q   <= c1_d;
            d1_q   <= d1_d;
            c2_q   <= c2_d;
            d2_q   <= d2_d;
            c3_q   <= c3_d;
            cnt_q  <= cnt_d;
            warm_q <= warm_d;
            t_q    <= t_d;
            v_q    <= v_d;
            data_q <= data_d;
            stb_q  <= stb_d;
        end
    end

    assign oDATA   = data_q;
    assign oSTROBE = stb_q;
endmodule

// File: tb/tb_sd_demodulator.sv
// tb_sd_demodulator: checks the CIC decimator against a windowed-convolution reference model.
module tb_sd_demodulator;
    localparam int P    = 24;
    localparam int D    = 5;
    localparam int R    = 32;
    localparam int TAPS = 3*R-2;
    localparam int FS   = 1 << (3*D);
    localparam logic [P-1:0] MID = P'(1) << (P-1);

    logic         iCLK = 1'b0, iRESET = 1'b1, iBIT = 1'b0;
    logic [P-1:0] oDATA;
    logic         oSTROBE;

    sd_demodulator #(.pBITS(P), .pDEC_BITS(D)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iBIT(iBIT), .oDATA(oDATA), .oSTROBE(oSTROBE)
    );

    always #5 iCLK = ~iCLK;

    int n_cmp = 0, n_bad = 0;
    int e;
    int x[0:8191];
    int h[0:TAPS-1];
    logic [P-1:0] exp_data;

    typedef struct {
        int           mode;
        logic [P-1:0] want;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at e=%0d: got %h want %h", name, e, act, want);
        end
    endtask

    // Output = bitstream convolved with the boxcar^3 impulse response, then clamp/offset/align.
    function automatic logic [P-1:0] model(input int n);
        longint y = 0;
        for (int m = 0; m < TAPS; m++)
            if (n - 2 - m >= 1) y += longint'(h[m]) * x[n-2-m];
        if (y > FS - 1) y = FS - 1;
        return P'((y + FS) << (P - 3*D - 1));
    endfunction

    task automatic step(input logic b);
        iBIT = b;
        @(posedge iCLK);
        e++;
        x[e+1] = b ? 1 : -1;
        #1;
        if (e % R == 3 && e >= 4*R+3) exp_data = model(e - 4);
        chk("strobe", oSTROBE, 32'(e % R == 3 && e >= 4*R+3));
        chk("data", oDATA, exp_data);
    endtask

    task automatic do_reset;
        iRESET = 1'b1;
        iBIT = 1'b0;
        @(posedge iCLK);
        #1;
        iRESET = 1'b0;
        e = 0;
        foreach (x[i]) x[i] = 0;
        x[1] = -1;
        exp_data = MID;
        chk("rst_data", oDATA, MID);
        chk("rst_strobe", oSTROBE, 0);
    endtask

    initial begin
        vec_t tbl[3];
        int b2[0:2*R-2];
        int ns, t0, acc, lvl, post, diff, dens;
        bit switched;
        tbl[0] = '{1, 24'hFFFF00};
        tbl[1] = '{0, 24'h000000};
        tbl[2] = '{2, 24'h800000};
        for (int i = 0; i < 2*R-1; i++) begin
            b2[i] = 0;
            for (int a = 0; a < R; a++) if (i - a >= 0 && i - a < R) b2[i]++;
        end
        for (int i = 0; i < TAPS; i++) begin
            h[i] = 0;
            for (int a = 0; a < R; a++) if (i - a >= 0 && i - a <= 2*R-2) h[i] += b2[i-a];
        end

        for (int i = 0; i < 3; i++) begin
            do_reset();
            ns = 0;
            for (int k = 0; k < 7*R+4; k++) begin
                step(tbl[i].mode == 2 ? e[0] : tbl[i].mode[0]);
                if (oSTROBE) begin
                    ns++;
                    chk("tbl_data", oDATA, tbl[i].want);
                end
            end
            chk("tbl_nstrobe", ns, 4);
        end

        // First strobe position, steady spacing, then a reset two clocks after a tick.
        do_reset();
        for (int k = 0; k < 200 && !oSTROBE; k++) step(1'b1);
        chk("first_strobe", e, 4*R+3);
        t0 = e;
        step(1'b1);
        for (int k = 0; k < 2*R && !oSTROBE; k++) step(1'b1);
        chk("spacing", e - t0, R);
        for (int k = 0; k < R+2 && e % R != 1; k++) step(1'b1);
        chk("pre_reset_phase", e % R, 1);
        do_reset();
        for (int k = 0; k < 200 && !oSTROBE; k++) step(1'b1);
        chk("first_after_reset", e, 4*R+3);

        // First-order modulator bitstream: 0x400000 then a tick-aligned step to 0xC00000.
        do_reset();
        acc = 0;
        lvl = 'h400000;
        switched = 0;
        post = 0;
        for (int k = 0; k < 18*R; k++) begin
            if (!switched && k >= 8*R && (e + 2) % R == 0) begin
                switched = 1;
                lvl = 'hC00000;
            end
            acc += lvl;
            if (acc >= (1 << 24)) begin
                acc -= (1 << 24);
                step(1'b1);
            end else step(1'b0);
            if (oSTROBE) begin
                if (switched) post++;
                diff = int'(oDATA) - (switched ? 'hC00000 : 'h400000);
                if (diff < 0) diff = -diff;
                if (!switched) chk("mod_low", 32'(diff <= 'h200), 1);
                else if (post >= 4) chk("mod_high", 32'(diff <= 'h200), 1);
            end
        end
        chk("mod_step_seen", 32'(post >= 6), 1);

        // Long full-scale run so the integrators wrap many times, then mixed-density random bits.
        do_reset();
        for (int k = 0; k < 1500; k++) step(1'b1);
        dens = 50;
        for (int k = 0; k < 1500; k++) begin
            if (k % 256 == 0) dens = $urandom_range(0, 100);
            step(($urandom % 100) < dens);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
